fp_norm_sequencer: RTL and testbench
====================================

// Module: fp_norm_sequencer
// PURPOSE
//  Post-add normalization controller for the 32-bit FP adder. Takes the raw 28-bit sum
//  (bit27 carry, bit26 hidden, 23 frac, 3 GRS) with its exponent, and drives the
//  external left-shift datapath over multiple cycles until bit26=1 or the exponent floor
//  is reached. Also handles 1-bit carry renormalization. Sits between adder and rounder.
// PARAMETERS
//  EXP_W     8   exponent width
//  MAX_STEP  8   max left shift per cycle, legal 1..26
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  in_valid     in   1      input beat valid
//  in_ready     out  1      input accepted when in_valid&&in_ready
//  in_mant      in   28     raw mantissa sum
//  in_exp       in   EXP_W  biased exponent
//  in_sign      in   1      sign, passed through
//  sh_data_out  out  28     operand to shifter (= working mantissa register)
//  sh_amount    out  5      shift amount to shifter; 0 outside SHIFT
//  sh_data_in   in   28     shifter result, sampled in SHIFT
//  out_valid    out  1      result valid, held until out_ready
//  out_ready    in   1      downstream accept
//  out_mant     out  28     normalized mantissa
//  out_exp      out  EXP_W  adjusted exponent
//  out_sign     out  1      sign
//  out_zero     out  1      result is exact zero
//  out_ovf      out  1      exponent overflow (carry into all-ones exponent)
// BEHAVIOUR
//  Reset: state IDLE; all registers, out_* and sh_* = 0; in_ready = (state==IDLE) decode.
//  IDLE : in_ready=1. On accept capture mant/exp/sign -> EVAL.
//  EVAL (1 cycle), priority order:
//   mant==0       -> mant=0, exp=0, zero=1 -> DONE.
//   mant[27]      -> mant=(mant>>1)|mant[0], exp+1; if new exp==all-ones: mant=0, ovf=1. -> DONE.
//   mant[26]      -> if exp==0 then exp=1. -> DONE.
//   exp<=1        -> exp=0 (denormal, no shift), uflow=1 -> DONE.
//   else          -> rem=lzc from bit26 (1..26) -> SHIFT.
//  SHIFT: amt=min(rem, MAX_STEP, exp-1); sh_amount=amt; mant<=sh_data_in; exp-=amt; rem-=amt.
//   rem reaches 0 -> DONE. exp reaches 1 with rem>0 -> exp=0, uflow=1 -> DONE (same edge).
//  DONE : out_valid=1, outputs stable until out_ready; on out_ready -> IDLE.
//  in_ready=0 in EVAL/SHIFT/DONE; accept never overlaps a DONE handshake (no same-cycle
//   refill); next accept earliest the cycle after out_ready.
//  Latency from accept edge: out_valid at +2 (no shift) or +2+ceil-steps in SHIFT.
//  Shifter is combinational; sh_data_out/sh_amount change only at clock edges.
//  rst_n low at any time aborts the operation; no partial result is ever presented.
// CONFIGURATION
//  NORM_UFLOW_FLAG_EN defined: extra port out_uflow (out, 1) = denormal clamp occurred,
//   reset 0, valid with out_valid. Undefined: port absent, uflow register not built;
//   datapath behaviour identical.
// TESTING
//  mant=0x4000000 exp=0x80 -> out_mant 0x4000000, exp 0x80, out_valid 2 cycles after accept, sh_amount stays 0.
//  mant=0x0000008 exp=0x80 MAX_STEP=8 -> sh_amount 8,8,7; out_mant 0x4000000, exp 0x69.
//  mant=0x8000001 exp=0x80 -> out_mant 0x4000001, exp 0x81; exp=0xFE -> ovf=1, exp 0xFF, mant 0.
//  mant=0x0000100 exp=5 -> one shift of 4; out_mant 0x0001000, exp 0, out_uflow=1 (macro on).
//  mant=0 -> out_zero=1, mant 0, exp 0; out_ready low 5 cycles -> outputs held, in_ready 0.
//  rst_n pulsed mid-SHIFT -> out_valid never rises, in_ready=1 after release, next op correct.

Source files
------------

// File: rtl/fp_norm_sequencer.sv
// Post-add normalization controller: drives an external left shifter until the hidden bit is set.
// Optional NORM_UFLOW_FLAG_EN adds the out_uflow port and its register. EXP_W must be >= 5.
module fp_norm_sequencer #(
    parameter int EXP_W    = 8,
    parameter int MAX_STEP = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [27:0]      in_mant,
    input  logic [EXP_W-1:0] in_exp,
    input  logic             in_sign,
    output logic [27:0]      sh_data_out,
    output logic [4:0]       sh_amount,
    input  logic [27:0]      sh_data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [27:0]      out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_sign,
    output logic             out_zero,
    output logic             out_ovf
`ifdef NORM_UFLOW_FLAG_EN
    ,
    output logic             out_uflow
`endif
);

    typedef enum logic [1:0] {IDLE, EVAL, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [27:0]        mant_q;
    logic [EXP_W-1:0]   exp_q;
    logic               sign_q, zero_q, ovf_q;
    logic [4:0]         rem_q;
`ifdef NORM_UFLOW_FLAG_EN
    logic               uflow_q;
`endif

    logic [4:0]         lzc, amt, rem_next;
    logic [EXP_W-1:0]   exp_m1, exp_inc, exp_next_sh;
    logic               no_shift;

    // Leading-zero count measured from the hidden-bit position (bit 26).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        lzc = 5'd0;
        for (int i = 0; i <= 26; i++) begin
            if (mant_q[i]) lzc = 5'(26 - i);
        end
    end

    // Step size limited by remaining distance, per-cycle shifter reach and exponent floor.
    always_comb begin
        exp_m1 = exp_q - EXP_W'(1);
        amt    = rem_q;
        if (amt > 5'(MAX_STEP)) amt = 5'(MAX_STEP);
        if (exp_m1 < EXP_W'(amt)) amt = exp_m1[4:0];
    end

    assign rem_next    = rem_q - amt;
    assign exp_next_sh = exp_q - EXP_W'(amt);
    assign exp_inc     = exp_q + EXP_W'(1);
    assign no_shift    = (mant_q == 28'd0) || mant_q[27] || mant_q[26] || (exp_q <= EXP_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (in_valid) state_d = EVAL;
            EVAL:  state_d = no_shift ? DONE : SHIFT;
            SHIFT: if (rem_next == 5'd0 || exp_next_sh == EXP_W'(1)) state_d = DONE;
            DONE:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        sh_amount = (state_q == SHIFT) ? amt : 5'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mant_q  <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            rem_q   <= '0;
`ifdef NORM_UFLOW_FLAG_EN
            uflow_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    mant_q  <= in_mant;
                    exp_q   <= in_exp;
                    sign_q  <= in_sign;
                    zero_q  <= 1'b0;
                    ovf_q   <= 1'b0;
                    rem_q   <= '0;
`ifdef NORM_UFLOW_FLAG_EN
                    uflow_q <= 1'b0;
`endif
                end
                EVAL: begin
                    if (mant_q == 28'd0) begin
                        exp_q  <= '0;
                        zero_q <= 1'b1;
                    end else if (mant_q[27]) begin
                        // Carry renormalization keeps the shifted-out bit as sticky.
                        exp_q <= exp_inc;
                        if (exp_inc == '1) begin
                            mant_q <= '0;
                            ovf_q  <= 1'b1;
                        end else begin
                            mant_q <= {1'b0, mant_q[27:1]} | {27'd0, mant_q[0]};
                        end
                    end else if (mant_q[26]) begin
                        if (exp_q == '0) exp_q <= EXP_W'(1);
                    end else if (exp_q <= EXP_W'(1)) begin
                        exp_q <= '0;
`ifdef NORM_UFLOW_FLAG_EN
                        uflow_q <= 1'b1;
`endif
                    end else begin
                        rem_q <= lzc;
                    end
                end
                SHIFT: begin
                    mant_q <= sh_data_in;
                    rem_q  <= rem_next;
                    if (rem_next != 5'd0 && exp_next_sh == EXP_W'(1)) begin
                        exp_q <= '0;
`ifdef NORM_UFLOW_FLAG_EN
                        uflow_q <= 1'b1;
`endif
                    end else begin
                        exp_q <= exp_next_sh;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sh_data_out = mant_q;
    assign out_mant    = mant_q;
    assign out_exp     = exp_q;
    assign out_sign    = sign_q;
    assign out_zero    = zero_q;
    assign out_ovf     = ovf_q;
`ifdef NORM_UFLOW_FLAG_EN
    assign out_uflow   = uflow_q;
`endif

endmodule

// File: tb/tb_fp_norm_sequencer.sv
// Scoreboard bench for fp_norm_sequencer with a behavioural combinational left shifter.
module tb_fp_norm_sequencer;

    typedef struct {
        logic [27:0] mant;
        logic [7:0]  exp;
        logic        sign, zero, ovf, uflow;
        int          lat;
        logic [31:0] sig;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [27:0] in_mant = '0;
    logic [7:0]  in_exp = '0;
    logic        in_sign = 1'b0;
    logic [27:0] sh_data_out, sh_data_in;
    logic [4:0]  sh_amount;
    logic        out_valid, out_ready = 1'b1;
    logic [27:0] out_mant;
    logic [7:0]  out_exp;
    logic        out_sign, out_zero, out_ovf;
`ifdef NORM_UFLOW_FLAG_EN
    logic        out_uflow;
`endif

    int          total = 0, bad = 0;
    exp_t        sb[$];
    exp_t        cur;
    bit          counting = 0, seen = 0;
    int          cyc = 0;
    logic [31:0] sig = '0;

    always #5 clk = ~clk;
    assign sh_data_in = sh_data_out << sh_amount;

    fp_norm_sequencer #(.EXP_W(8), .MAX_STEP(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mant(in_mant), .in_exp(in_exp), .in_sign(in_sign),
        .sh_data_out(sh_data_out), .sh_amount(sh_amount), .sh_data_in(sh_data_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant),
        .out_exp(out_exp), .out_sign(out_sign), .out_zero(out_zero), .out_ovf(out_ovf)
`ifdef NORM_UFLOW_FLAG_EN
        , .out_uflow(out_uflow)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [27:0] m, input logic [7:0] x, input logic s,
                                input logic z, input logic o, input logic u,
                                input int lat, input logic [31:0] sg);
        exp_t e;
        e.mant = m; e.exp = x; e.sign = s; e.zero = z; e.ovf = o; e.uflow = u;
        e.lat = lat; e.sig = sg;
        return e;
    endfunction

    // Monitor: latency and shift-amount signature per operation, compared on out_valid.
    always @(negedge clk) begin
        if (!rst_n) begin
            counting = 0;
            seen     = 0;
        end else begin
            if (counting) begin
                cyc++;
                if (sh_amount != 5'd0) sig = {sig[26:0], sh_amount};
            end
            if (in_valid && in_ready) begin
                counting = 1; cyc = 0; sig = '0;
            end
            if (out_valid) begin
                if (!seen) begin
                    seen = 1;
                    counting = 0;
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_out: out_valid with empty scoreboard, mant %h", out_mant);
                    end else begin
                        cur = sb.pop_front();
                        check("mant", 32'(out_mant), 32'(cur.mant));
                        check("exp", 32'(out_exp), 32'(cur.exp));
                        check("sign", 32'(out_sign), 32'(cur.sign));
                        check("zero", 32'(out_zero), 32'(cur.zero));
                        check("ovf", 32'(out_ovf), 32'(cur.ovf));
`ifdef NORM_UFLOW_FLAG_EN
                        check("uflow", 32'(out_uflow), 32'(cur.uflow));
`endif
                        check("latency", 32'(cyc), 32'(cur.lat));
                        check("shift_seq", sig, cur.sig);
                        check("sh_amount_done", 32'(sh_amount), 32'd0);
                    end
                end else begin
                    check("hold_mant", 32'(out_mant), 32'(cur.mant));
                    check("hold_exp", 32'(out_exp), 32'(cur.exp));
                    check("hold_zero", 32'(out_zero), 32'(cur.zero));
                    check("in_ready_busy", 32'(in_ready), 32'd0);
                end
                if (out_ready) seen = 0;
            end
        end
    end

    task automatic send(input logic [27:0] m, input logic [7:0] x, input logic s,
                        input bit push, input exp_t e);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        @(posedge clk); #1;
        in_mant = m; in_exp = x; in_sign = s; in_valid = 1'b1;
        if (push) sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_sh_amount", 32'(sh_amount), 32'd0);
        check("rst_sh_data", 32'(sh_data_out), 32'd0);
        check("rst_out_mant", 32'(out_mant), 32'd0);
        check("rst_out_exp", 32'(out_exp), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        send(28'h4000000, 8'h80, 1'b0, 1, mk(28'h4000000, 8'h80, 0, 0, 0, 0, 2, 32'd0));
        send(28'h0000008, 8'h80, 1'b0, 1, mk(28'h4000000, 8'h69, 0, 0, 0, 0, 5, 32'({5'd8, 5'd8, 5'd7})));
        send(28'h8000001, 8'h80, 1'b1, 1, mk(28'h4000001, 8'h81, 1, 0, 0, 0, 2, 32'd0));
        send(28'h8000001, 8'hFE, 1'b0, 1, mk(28'h0000000, 8'hFF, 0, 0, 1, 0, 2, 32'd0));
        send(28'hC000002, 8'h10, 1'b0, 1, mk(28'h6000001, 8'h11, 0, 0, 0, 0, 2, 32'd0));
        send(28'h0000100, 8'h05, 1'b0, 1, mk(28'h0001000, 8'h00, 0, 0, 0, 1, 3, 32'd4));
        send(28'h4000005, 8'h00, 1'b1, 1, mk(28'h4000005, 8'h01, 1, 0, 0, 0, 2, 32'd0));
        send(28'h0000100, 8'h01, 1'b0, 1, mk(28'h0000100, 8'h00, 0, 0, 0, 1, 2, 32'd0));
        send(28'h2000000, 8'h10, 1'b1, 1, mk(28'h4000000, 8'h0F, 1, 0, 0, 0, 3, 32'd1));
        send(28'h1000000, 8'h03, 1'b0, 1, mk(28'h4000000, 8'h01, 0, 0, 0, 0, 3, 32'd2));
        send(28'h0000001, 8'h80, 1'b0, 1, mk(28'h4000000, 8'h66, 0, 0, 0, 0, 6, 32'({5'd8, 5'd8, 5'd8, 5'd2})));

        // Zero result with downstream stalled for 5 cycles.
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1 out_ready = 1'b0;
        send(28'h0000000, 8'h33, 1'b1, 1, mk(28'h0000000, 8'h00, 1, 1, 0, 0, 2, 32'd0));
        wait_valid();
        repeat (5) @(negedge clk);
        @(posedge clk); #1 out_ready = 1'b1;

        // Reset pulse in the middle of a multi-step shift.
        send(28'h0000008, 8'h80, 1'b0, 0, mk(28'h0, 8'h0, 0, 0, 0, 0, 0, 32'd0));
        n = 0;
        @(negedge clk);
        while (sh_amount == 5'd0 && n < 20) begin @(negedge clk); n++; end
        check("reached_shift", 32'(sh_amount != 5'd0), 32'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_sh_amount", 32'(sh_amount), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (8) begin
            @(negedge clk);
            check("post_rst_no_valid", 32'(out_valid), 32'd0);
        end
        send(28'h0000008, 8'h80, 1'b0, 1, mk(28'h4000000, 8'h69, 0, 0, 0, 0, 5, 32'({5'd8, 5'd8, 5'd7})));

        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin @(negedge clk); n++; end
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
